// File: rtl/rd_req_sched.sv
// Read request scheduler: FIFO-queued client reads issued one at a time to the go/rd/ds read FSM.
// Push->go is 2 cycles; req_ready is !full with no bypass. Optional watchdog: RDSCHED_TIMEOUT_EN.
module rd_req_sched #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   output logic          go,
   output logic [AW-1:0] addr,
   input  logic          rd,
   input  logic          ds,
   input  logic [DW-1:0] rdata_in,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic [AW-1:0] rsp_addr,
   output logic          rsp_err,
   output logic          busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] mem_q [DEPTH];
   logic [AW-1:0] mem_d [DEPTH];
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] rsp_addr_q, rsp_addr_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          push, pop;

`ifdef RDSCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT) + 1;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          rsp_err_q, rsp_err_d;
`endif

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_d      = mem_q;
      addr_d     = addr_q;
      rsp_addr_d = rsp_addr_q;
      rsp_data_d = rsp_data_q;
`ifdef RDSCHED_TIMEOUT_EN
      cnt_d      = cnt_q;
      rsp_err_d  = rsp_err_q;
`endif
      push = req_valid && req_ready;
      pop  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop        = 1'b1;
               addr_d     = mem_q[rd_ptr_q];
               rsp_addr_d = mem_q[rd_ptr_q];
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (rd) begin
               state_d = S_WAIT;
`ifdef RDSCHED_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_WAIT: begin
            if (ds) begin
               rsp_data_d = rdata_in;
               state_d    = S_RESP;
`ifdef RDSCHED_TIMEOUT_EN
               rsp_err_d  = 1'b0;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               // Watchdog expiry still yields a response so the client never stalls.
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = req_addr;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         addr_q     <= '0;
         rsp_addr_q <= '0;
         rsp_data_q <= '0;
`ifdef RDSCHED_TIMEOUT_EN
         cnt_q      <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         rsp_addr_q <= rsp_addr_d;
         rsp_data_q <= rsp_data_d;
`ifdef RDSCHED_TIMEOUT_EN
         cnt_q      <= cnt_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   // Storage needs no reset: count_q gates every read of it.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign req_ready = (count_q != CW'(DEPTH));
   assign go        = (state_q == S_ISSUE);
   assign addr      = addr_q;
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = rsp_addr_q;
   assign busy      = (state_q != S_IDLE) || (count_q != '0);
`ifdef RDSCHED_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rd_req_sched.sv
// Directed bench for rd_req_sched: reset, single read, FIFO fill/backpressure, response stall, mid-read reset, optional watchdog.
module tb_rd_req_sched;

   logic       clock;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_addr;
   logic       go;
   logic [7:0] addr;
   logic       rd;
   logic       ds;
   logic [7:0] rdata_in;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [7:0] rsp_addr;
   logic       rsp_err;
   logic       busy;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [7:0] pq[$];

   rd_req_sched #(.AW(8), .DW(8), .DEPTH(4), .TIMEOUT(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .go        (go),
      .addr      (addr),
      .rd        (rd),
      .ds        (ds),
      .rdata_in  (rdata_in),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; the client retires its head request if it was accepted at this edge.
   task automatic step();
      logic fire;
      fire = req_valid && req_ready;
      @(posedge clock);
      #1;
      if (fire && pq.size() > 0) void'(pq.pop_front());
      req_valid = (pq.size() != 0);
      if (pq.size() != 0) req_addr = pq[0];
   endtask

   task automatic load(input logic [7:0] a);
      pq.push_back(a);
      req_valid = 1'b1;
      req_addr  = pq[0];
   endtask

   // Drive one read through the FSM; returns with the response presented.
   task automatic run_read(input logic [7:0] ea, input logic [7:0] d);
      int n = 0;
      while (!go && n < 20) begin
         step();
         n++;
      end
      chk("go_seen", go, 1);
      chk("issue_addr", addr, ea);
      step();
      chk("go_hold", go, 1);
      rd = 1'b1;
      step();
      rd = 1'b0;
      chk("go_drop", go, 0);
      chk("addr_stable", addr, ea);
      ds = 1'b1;
      rdata_in = d;
      step();
      ds = 1'b0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, d);
      chk("rsp_addr", rsp_addr, ea);
      chk("rsp_err", rsp_err, 0);
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_addr = '0; rd = 1'b0; ds = 1'b0;
      rdata_in = '0; rsp_ready = 1'b1;
      step(); step();
      reset = 1'b0;
      step(); step(); step();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_go", go, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", addr, 0);
      chk("rst_rsp_data", rsp_data, 0);

      // Single read and push-to-go latency
      load(8'h3C);
      step();
      chk("lat_n1_go", go, 0);
      chk("lat_n1_busy", busy, 1);
      step();
      chk("lat_n2_go", go, 1);
      run_read(8'h3C, 8'hA5);
      step();
      chk("single_done_valid", rsp_valid, 0);
      chk("single_done_busy", busy, 0);

      // Stalled response while the FIFO fills behind it
      rsp_ready = 1'b0;
      load(8'h20);
      run_read(8'h20, 8'h5A);
      for (int i = 0; i < 5; i++) load(8'h10 + 8'(i));
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", rsp_data, 8'h5A);
         chk("stall_go", go, 0);
      end
      chk("full_req_ready", req_ready, 0);
      chk("fifth_held", pq.size(), 1);
      rsp_ready = 1'b1;
      step();
      chk("release_valid", rsp_valid, 0);
      chk("release_still_full", req_ready, 0);
      step();
      chk("pop_go", go, 1);
      chk("pop_req_ready", req_ready, 1);
      chk("no_bypass", pq.size(), 1);
      step();
      chk("fifth_accepted", pq.size(), 0);
      for (int i = 0; i < 5; i++) begin
         logic [7:0] a;
         a = 8'h10 + 8'(i);
         run_read(a, ~a);
      end
      step();
      chk("order_done_busy", busy, 0);

      // Reset in S_WAIT with two entries queued
      load(8'h30); load(8'h31); load(8'h32);
      for (int n = 0; n < 20 && !go; n++) step();
      chk("mid_go", go, 1);
      rd = 1'b1;
      step();
      rd = 1'b0;
      chk("mid_wait_go", go, 0);
      chk("mid_wait_busy", busy, 1);
      chk("mid_all_queued", pq.size(), 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_go", go, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_addr", addr, 0);
      ds = 1'b1; rdata_in = 8'h77; rd = 1'b1;
      step();
      ds = 1'b0; rd = 1'b0;
      chk("late_ds_valid", rsp_valid, 0);
      chk("late_rd_go", go, 0);
      step();
      chk("late_ds_data", rsp_data, 0);
      chk("late_ds_busy", busy, 0);

`ifdef RDSCHED_TIMEOUT_EN
      begin
         int n;
         rsp_ready = 1'b0;
         load(8'h40);
         for (int k = 0; k < 20 && !go; k++) step();
         chk("to_go", go, 1);
         rd = 1'b1;
         step();
         rd = 1'b0;
         n = 0;
         while (!rsp_valid && n < 40) begin
            step();
            n++;
         end
         chk("to_wait_cycles", n, 16);
         chk("to_err", rsp_err, 1);
         chk("to_data", rsp_data, 0);
         chk("to_addr", rsp_addr, 8'h40);
         ds = 1'b1; rdata_in = 8'hC3;
         step();
         ds = 1'b0;
         chk("to_late_ds_err", rsp_err, 1);
         chk("to_late_ds_data", rsp_data, 0);
         rsp_ready = 1'b1;
         step();
         chk("to_release", rsp_valid, 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/rd_req_sched.md
Name: rd_req_sched

Overview:
- Upstream request scheduler for the go/ws/rd/ds read-cycle FSM.
- Queues read requests (address) from a valid/ready client in a small FIFO and issues them one at a time to the FSM with a go/rd handshake.
- Captures read data on ds and returns it to the client as a valid/ready response.
- Keeps at most one read in flight; requests are serviced in order.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- DEPTH, 4, request FIFO entries; power of two, >=2.
- TIMEOUT, 16, watchdog limit in cycles; used only with RDSCHED_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  FIFO can accept; equals !full.
- req_addr  in  AW  request address.
- go  out  1  start strobe to read FSM.
- addr  out  AW  address of read in flight.
- rd  in  1  read-active from FSM; acknowledges go.
- ds  in  1  data-strobe pulse from FSM; read complete.
- rdata_in  in  DW  read data, valid when ds=1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  client accepts response.
- rsp_data  out  DW  captured read data.
- rsp_addr  out  AW  address of the response.
- rsp_err  out  1  timeout flag; tied 0 without the feature.
- busy  out  1  state != S_IDLE or FIFO non-empty.

Behaviour:
- Reset (sampled on the clock edge): FIFO empty, pointers and count 0, state S_IDLE. go=0, addr=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, busy=0, req_ready=1.
- FIFO:
  - Push when req_valid && req_ready.
  - Pop only on the S_IDLE->S_ISSUE transition.
  - Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
  - When full, req_ready=0. There is no same-cycle bypass when full, even if a pop occurs in that cycle.
  - Push and pop in the same cycle leave count unchanged.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
  - S_IDLE: if FIFO non-empty, pop the head into addr/rsp_addr, then go to S_ISSUE.
  - S_ISSUE: go=1 (decoded from state). Stay until rd=1 is sampled, then go to S_WAIT; go is 0 from the next cycle.
  - S_WAIT: go=0 and addr held stable. On ds=1, register rdata_in into rsp_data, set rsp_err=0, go to S_RESP.
  - S_RESP: rsp_valid=1; rsp_data/addr/err held stable. On rsp_ready=1, go to S_IDLE. If rsp_ready is already 1 on entry, S_RESP lasts exactly one cycle.
- Latency: request pushed at edge N → go=1 in cycle N+2 (one cycle to update the count, one for S_IDLE→S_ISSUE).
- Back-to-back: at least one S_IDLE cycle separates consecutive go assertions.
- addr changes only on a pop.
- ds in any state other than S_WAIT is ignored.
- rd=1 outside S_ISSUE is ignored.
- A reset asserted mid-read returns to the reset values immediately. Queued requests and any pending response are discarded.

Optional Feature:
- Macro: RDSCHED_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to S_WAIT and increments each cycle in S_WAIT.
  - If it reaches TIMEOUT-1 without ds, go to S_RESP with rsp_err=1 and rsp_data=0.
  - A late ds after this is ignored per the rule above.
  - The counter width is $clog2(TIMEOUT)+1.
- Without the macro: no counter; S_WAIT waits indefinitely; rsp_err is constant 0.

Test Plan:
- Reset, then idle 3 cycles → req_ready=1, go=0, rsp_valid=0, busy=0.
- Push addr 0x3C, rd model returns rd=1 one cycle after go, ds one cycle later with rdata_in=0xA5 → go high exactly until rd seen; rsp_valid=1, rsp_data=0xA5, rsp_addr=0x3C, rsp_err=0.
- Push 5 requests (0x10..0x14) back-to-back with DEPTH=4 and no reads completing → req_ready drops after the 4th FIFO entry; 5th held by client and accepted after the first pop; responses return in order 0x10..0x14.
- Hold rsp_ready=0 for 4 cycles after a ds → rsp_valid stays 1 with stable data, no new go issued; releases on rsp_ready=1.
- Assert reset while in S_WAIT with 2 queued entries → next cycle: state S_IDLE, FIFO empty, go=0, busy=0; a subsequent ds is ignored.
- With RDSCHED_TIMEOUT_EN and TIMEOUT=16, never assert ds → rsp_valid=1 with rsp_err=1, rsp_data=0 after 16 S_WAIT cycles; a later ds has no effect.
